mtx_wb_writeback: RTL and testbench

// - Writeback-stage consumer of the MEM/WB pipeline register outputs.
// - Drives the scalar register file write port and the single-word matrix register file write port.
// - A MOPA result row (4 words) is serialised into 4 one-word beats. The pipeline is stalled while the beats drain.
// - Scalar writeback is combinational. Matrix writeback uses a 2-state FSM with a beat counter.

---
 rtl/mtx_wb_writeback.sv | 152 +++++++++++++++
 tb/tb_mtx_wb_writeback.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_wb_writeback.sv
// ----------------------------------------------------------------------------
// mtx_wb_writeback: writeback stage driving the scalar and matrix RF write ports
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mtx_wb_writeback #(
  parameter int XLEN  = 32,
  parameter int NCOLS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         wb_mem_data,
  input  logic [XLEN-1:0]         wb_alu_o,
  input  logic [4:0]              wb_rd,
  input  logic                    wb_mem2reg,
  input  logic                    wb_regs_write,
  input  logic [1:0]              wb_matrix_index,
  input  logic                    wb_mem2matrix,
  input  logic                    wb_matrix_write,
  input  logic                    wb_matrix_write_mopa,
  input  logic [1:0]              wb_mem_matrix2reg,
  input  logic [XLEN-1:0]         wb_matrix_line_data,
  input  logic                    wb_mem_reg2matrix,
  input  logic [XLEN-1:0]         wb_regs_data1,
  input  logic [NCOLS*XLEN-1:0]   wb_matrix_mul_o,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    mx_we,
  output logic [1:0]              mx_tile,
  output logic [1:0]              mx_row,
  output logic [1:0]              mx_col,
  output logic [XLEN-1:0]         mx_wdata,
  output logic                    wb_stall
);

  localparam logic [1:0] c_LAST_BEAT = 2'(NCOLS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_beat;
  logic [1:0]        r_tile;
  logic [1:0]        r_row;
  logic [XLEN-1:0]   r_words [1:NCOLS-1];

  logic              w_idle;
  logic              w_mopa_req;
  logic              w_last;
  logic              w_unused;

  assign w_idle     = (r_state == S_IDLE);
  assign w_mopa_req = w_idle && wb_matrix_write && wb_matrix_write_mopa;
  assign w_last     = (r_beat == c_LAST_BEAT);

  // Only the row/col fields of the ALU result address the matrix.
  assign w_unused = ^{wb_alu_o[XLEN-1:6], wb_alu_o[1:0]};

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    mx_we    = 1'b0;
    mx_tile  = '0;
    mx_row   = '0;
    mx_col   = '0;
    mx_wdata = '0;
    wb_stall = 1'b0;
    if (rst) begin
      if (w_idle) begin
        rf_we    = wb_regs_write && (wb_rd != 5'd0);
        rf_waddr = wb_rd;
        if (wb_mem2reg)
          rf_wdata = wb_mem_data;
        else if (wb_mem_matrix2reg != 2'd0)
          rf_wdata = wb_matrix_line_data;
        else
          rf_wdata = wb_alu_o;

        if (wb_matrix_write) begin
          mx_tile = wb_matrix_index;
          mx_row  = wb_alu_o[5:4];
          if (wb_matrix_write_mopa) begin
            // Column 0 goes out immediately; the rest drain from the latches.
            mx_we    = 1'b1;
            mx_col   = 2'd0;
            mx_wdata = wb_matrix_mul_o[XLEN-1:0];
            wb_stall = 1'b1;
          end else if (wb_mem2matrix) begin
            mx_we    = 1'b1;
            mx_col   = wb_alu_o[3:2];
            mx_wdata = wb_mem_data;
          end else if (wb_mem_reg2matrix) begin
            mx_we    = 1'b1;
            mx_col   = wb_alu_o[3:2];
            mx_wdata = wb_regs_data1;
          end
        end
      end else begin
        mx_we    = 1'b1;
        mx_tile  = r_tile;
        mx_row   = r_row;
        mx_col   = r_beat;
        mx_wdata = r_words[r_beat];
        wb_stall = !w_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_tile  <= 2'd0;
      r_row   <= 2'd0;
      for (int i = 1; i < NCOLS; i++)
        r_words[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mopa_req) begin
            r_state <= S_BURST;
            r_beat  <= 2'd1;
            r_tile  <= wb_matrix_index;
            r_row   <= wb_alu_o[5:4];
            for (int i = 1; i < NCOLS; i++)
              r_words[i] <= wb_matrix_mul_o[i*XLEN +: XLEN];
          end
        end
        S_BURST: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_beat  <= 2'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mtx_wb_writeback.sv
// ----------------------------------------------------------------------------
// tb_mtx_wb_writeback: directed vector bench for mtx_wb_writeback
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mtx_wb_writeback;

  logic          clk;
  logic          rst;
  logic [31:0]   wb_mem_data;
  logic [31:0]   wb_alu_o;
  logic [4:0]    wb_rd;
  logic          wb_mem2reg;
  logic          wb_regs_write;
  logic [1:0]    wb_matrix_index;
  logic          wb_mem2matrix;
  logic          wb_matrix_write;
  logic          wb_matrix_write_mopa;
  logic [1:0]    wb_mem_matrix2reg;
  logic [31:0]   wb_matrix_line_data;
  logic          wb_mem_reg2matrix;
  logic [31:0]   wb_regs_data1;
  logic [127:0]  wb_matrix_mul_o;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          mx_we;
  logic [1:0]    mx_tile;
  logic [1:0]    mx_row;
  logic [1:0]    mx_col;
  logic [31:0]   mx_wdata;
  logic          wb_stall;

  int passed = 0;
  int total  = 0;

  mtx_wb_writeback #(.XLEN(32), .NCOLS(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wb_mem_data          (wb_mem_data),
    .wb_alu_o             (wb_alu_o),
    .wb_rd                (wb_rd),
    .wb_mem2reg           (wb_mem2reg),
    .wb_regs_write        (wb_regs_write),
    .wb_matrix_index      (wb_matrix_index),
    .wb_mem2matrix        (wb_mem2matrix),
    .wb_matrix_write      (wb_matrix_write),
    .wb_matrix_write_mopa (wb_matrix_write_mopa),
    .wb_mem_matrix2reg    (wb_mem_matrix2reg),
    .wb_matrix_line_data  (wb_matrix_line_data),
    .wb_mem_reg2matrix    (wb_mem_reg2matrix),
    .wb_regs_data1        (wb_regs_data1),
    .wb_matrix_mul_o      (wb_matrix_mul_o),
    .rf_we                (rf_we),
    .rf_waddr             (rf_waddr),
    .rf_wdata             (rf_wdata),
    .mx_we                (mx_we),
    .mx_tile              (mx_tile),
    .mx_row               (mx_row),
    .mx_col               (mx_col),
    .mx_wdata             (mx_wdata),
    .wb_stall             (wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [4:0]   rd;
    logic         regs_write;
    logic         mem2reg;
    logic [1:0]   matrix2reg;
    logic [31:0]  mem_data;
    logic [31:0]  alu_o;
    logic [31:0]  line_data;
    logic         matrix_write;
    logic         mem2matrix;
    logic         reg2matrix;
    logic [31:0]  regs_data1;
    logic [1:0]   tile;
    logic         e_rf_we;
    logic [4:0]   e_rf_waddr;
    logic [31:0]  e_rf_wdata;
    logic         e_mx_we;
    logic [1:0]   e_tile;
    logic [1:0]   e_row;
    logic [1:0]   e_col;
    logic [31:0]  e_mx_wdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic clear_inputs();
    wb_mem_data = '0; wb_alu_o = '0; wb_rd = '0; wb_mem2reg = 1'b0;
    wb_regs_write = 1'b0; wb_matrix_index = '0; wb_mem2matrix = 1'b0;
    wb_matrix_write = 1'b0; wb_matrix_write_mopa = 1'b0; wb_mem_matrix2reg = '0;
    wb_matrix_line_data = '0; wb_mem_reg2matrix = 1'b0; wb_regs_data1 = '0;
    wb_matrix_mul_o = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mx(input string name, input logic [1:0] tile, input logic [1:0] row,
                          input logic [1:0] col, input logic [31:0] data, input logic stall);
    check({name, " mx_we"}, 32'(mx_we), 32'd1);
    check({name, " mx_tile"}, 32'(mx_tile), 32'(tile));
    check({name, " mx_row"}, 32'(mx_row), 32'(row));
    check({name, " mx_col"}, 32'(mx_col), 32'(col));
    check({name, " mx_wdata"}, mx_wdata, data);
    check({name, " wb_stall"}, 32'(wb_stall), 32'(stall));
  endtask

  task automatic start_mopa(input logic [1:0] tile, input logic [31:0] alu, input logic [127:0] mul);
    wb_matrix_write = 1'b1;
    wb_matrix_write_mopa = 1'b1;
    wb_matrix_index = tile;
    wb_alu_o = alu;
    wb_matrix_mul_o = mul;
  endtask

  initial begin
    // name, rd, rw, m2r, mx2r, mem_data, alu, line, mw, m2m, r2m, rdata1, tile,
    // e_rf_we, e_waddr, e_wdata, e_mx_we, e_tile, e_row, e_col, e_mx_wdata
    vecs[0]  = '{"ld rd5",      5'd5,  1, 1, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'd0,
                 1, 5'd5,  32'hDEADBEEF, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[1]  = '{"ld rd0",      5'd0,  1, 1, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'd0,
                 0, 5'd0,  32'h0, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[2]  = '{"mx2reg",      5'd9,  1, 0, 2'd1, 32'h11111111, 32'hAAAA0000, 32'h12345678, 0, 0, 0, 32'h0, 2'd0,
                 1, 5'd9,  32'h12345678, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[3]  = '{"alu rd31",    5'd31, 1, 0, 2'd0, 32'h11111111, 32'hAAAA0000, 32'h12345678, 0, 0, 0, 32'h0, 2'd0,
                 1, 5'd31, 32'hAAAA0000, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[4]  = '{"mem over mx", 5'd3,  1, 1, 2'd2, 32'h0BADF00D, 32'hAAAA0000, 32'h12345678, 0, 0, 0, 32'h0, 2'd0,
                 1, 5'd3,  32'h0BADF00D, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[5]  = '{"mem2matrix",  5'd0,  0, 0, 2'd0, 32'h00000055, 32'h0000001C, 32'h0, 1, 1, 0, 32'h0, 2'd1,
                 0, 5'd0,  32'h0, 1, 2'd1, 2'd1, 2'd3, 32'h00000055};
    vecs[6]  = '{"reg2matrix",  5'd0,  0, 0, 2'd0, 32'h0, 32'h00000038, 32'h0, 1, 0, 1, 32'h00000077, 2'd3,
                 0, 5'd0,  32'h0, 1, 2'd3, 2'd3, 2'd2, 32'h00000077};
    vecs[7]  = '{"m2m over r2m",5'd0,  0, 0, 2'd0, 32'hA5A5A5A5, 32'h00000004, 32'h0, 1, 1, 1, 32'h5A5A5A5A, 2'd2,
                 0, 5'd0,  32'h0, 1, 2'd2, 2'd0, 2'd1, 32'hA5A5A5A5};
    vecs[8]  = '{"mw no src",   5'd0,  0, 0, 2'd0, 32'h1, 32'h3C, 32'h0, 1, 0, 0, 32'h2, 2'd1,
                 0, 5'd0,  32'h0, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[9]  = '{"src no mw",   5'd0,  0, 0, 2'd0, 32'h1, 32'h3C, 32'h0, 0, 1, 1, 32'h2, 2'd1,
                 0, 5'd0,  32'h0, 0, 2'd0, 2'd0, 2'd0, 32'h0};
    vecs[10] = '{"both ports",  5'd12, 1, 0, 2'd0, 32'hCAFEF00D, 32'h00000028, 32'h0, 1, 1, 0, 32'h0, 2'd2,
                 1, 5'd12, 32'h00000028, 1, 2'd2, 2'd2, 2'd2, 32'hCAFEF00D};

    clear_inputs();
    rst = 1'b0;
    // Drive a busy mix while in reset: every output must stay low.
    wb_regs_write = 1'b1; wb_rd = 5'd4; wb_mem2reg = 1'b1; wb_mem_data = 32'hFFFFFFFF;
    start_mopa(2'd3, 32'h3C, {4{32'hFFFFFFFF}});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset rf_waddr", 32'(rf_waddr), 32'd0);
    check("reset rf_wdata", rf_wdata, 32'd0);
    check("reset mx_we", 32'(mx_we), 32'd0);
    check("reset mx_fields", {24'd0, mx_tile, mx_row, mx_col, 2'd0}, 32'd0);
    check("reset mx_wdata", mx_wdata, 32'd0);
    check("reset wb_stall", 32'(wb_stall), 32'd0);
    clear_inputs();
    next_cycle();
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      wb_rd = vecs[i].rd; wb_regs_write = vecs[i].regs_write; wb_mem2reg = vecs[i].mem2reg;
      wb_mem_matrix2reg = vecs[i].matrix2reg; wb_mem_data = vecs[i].mem_data;
      wb_alu_o = vecs[i].alu_o; wb_matrix_line_data = vecs[i].line_data;
      wb_matrix_write = vecs[i].matrix_write; wb_mem2matrix = vecs[i].mem2matrix;
      wb_mem_reg2matrix = vecs[i].reg2matrix; wb_regs_data1 = vecs[i].regs_data1;
      wb_matrix_index = vecs[i].tile;
      @(negedge clk);
      check({vecs[i].name, " rf_we"}, 32'(rf_we), 32'(vecs[i].e_rf_we));
      if (vecs[i].e_rf_we) begin
        check({vecs[i].name, " rf_waddr"}, 32'(rf_waddr), 32'(vecs[i].e_rf_waddr));
        check({vecs[i].name, " rf_wdata"}, rf_wdata, vecs[i].e_rf_wdata);
      end
      if (vecs[i].e_mx_we)
        check_mx(vecs[i].name, vecs[i].e_tile, vecs[i].e_row, vecs[i].e_col, vecs[i].e_mx_wdata, 1'b0);
      else begin
        check({vecs[i].name, " mx_we"}, 32'(mx_we), 32'd0);
        check({vecs[i].name, " wb_stall"}, 32'(wb_stall), 32'd0);
      end
      next_cycle();
      clear_inputs();
    end

    // MOPA burst with inputs held, then a reg2matrix move right behind it.
    start_mopa(2'd2, 32'h20, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_mx($sformatf("mopa beat%0d", c), 2'd2, 2'd2, 2'(c), 32'(c + 1), c < 3);
      next_cycle();
    end
    clear_inputs();
    wb_matrix_write = 1'b1; wb_mem_reg2matrix = 1'b1; wb_regs_data1 = 32'h77;
    wb_alu_o = 32'h14; wb_matrix_index = 2'd0;
    @(negedge clk);
    check_mx("b2b move", 2'd0, 2'd1, 2'd1, 32'h77, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("b2b no extra beat", 32'(mx_we), 32'd0);
    next_cycle();

    // Reset lands after beat 1: remaining beats must be dropped.
    start_mopa(2'd1, 32'h30, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
    @(negedge clk);
    check_mx("abort beat0", 2'd1, 2'd3, 2'd0, 32'hD1, 1'b1);
    next_cycle();
    @(negedge clk);
    check_mx("abort beat1", 2'd1, 2'd3, 2'd1, 32'hD2, 1'b1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("abort rst mx_we", 32'(mx_we), 32'd0);
    check("abort rst mx_wdata", mx_wdata, 32'd0);
    check("abort rst wb_stall", 32'(wb_stall), 32'd0);
    check("abort rst rf_we", 32'(rf_we), 32'd0);
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort idle%0d mx_we", k), 32'(mx_we), 32'd0);
      check($sformatf("abort idle%0d wb_stall", k), 32'(wb_stall), 32'd0);
      next_cycle();
    end

    // MOPA wins over mem2matrix; scalar move-from-matrix fires alongside.
    start_mopa(2'd0, 32'h10, {32'h40, 32'h30, 32'h20, 32'h10});
    wb_mem2matrix = 1'b1; wb_mem_data = 32'h99;
    wb_regs_write = 1'b1; wb_rd = 5'd7; wb_mem_matrix2reg = 2'd1; wb_matrix_line_data = 32'hCAFE;
    @(negedge clk);
    check_mx("prio beat0", 2'd0, 2'd1, 2'd0, 32'h10, 1'b1);
    check("prio rf_we", 32'(rf_we), 32'd1);
    check("prio rf_waddr", 32'(rf_waddr), 32'd7);
    check("prio rf_wdata", rf_wdata, 32'hCAFE);
    next_cycle();
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check_mx($sformatf("prio beat%0d", c), 2'd0, 2'd1, 2'(c), 32'((c + 1) * 16), c < 3);
      check($sformatf("prio burst%0d rf_we", c), 32'(rf_we), 32'd0);
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    check("prio done mx_we", 32'(mx_we), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
